// File: rtl/music_box_pkg.sv
// Shared constants and types for the music box key path.
// Holds the default debounce timing and the saturating press-count helper.
package music_box_pkg;
    localparam int NUM_MUSIC_KEYS          = 6;
    localparam int CLOCK_HZ                = 50_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
    localparam int PRESS_COUNT_W           = 16;

    typedef logic [NUM_MUSIC_KEYS-1:0] music_keys_t;

    // Adds a small increment to the press count, sticking at all-ones instead of wrapping.
    function automatic logic [PRESS_COUNT_W-1:0] sat_add_count(
        input logic [PRESS_COUNT_W-1:0] count,
        input logic [7:0]               inc
    );
        logic [PRESS_COUNT_W:0] sum;
        sum = {1'b0, count} + {{(PRESS_COUNT_W-7){1'b0}}, inc};
        return sum[PRESS_COUNT_W] ? {PRESS_COUNT_W{1'b1}} : sum[PRESS_COUNT_W-1:0];
    endfunction
endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, stability counter and the accepted (stable) level.
// Press/release pulses are registered alongside the level so they line up with it.
module key_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            level         <= 1'b1;
            count         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= raw;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                level         <= sync2;
                count         <= '0;
                press_pulse   <= ~sync2;
                release_pulse <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/music_key_debouncer.sv
// Debounces the active-low music keys and produces press/release pulses plus a press tally.
// debugString = {10'b0, output_MusicKey, press_count}.
module music_key_debouncer
    import music_box_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_MUSIC_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clock_50Mhz,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] input_RawKey,
    output logic [NUM_KEYS-1:0] output_MusicKey,
    output logic [NUM_KEYS-1:0] keyPressPulse,
    output logic [NUM_KEYS-1:0] keyReleasePulse,
    output logic [31:0]         debugString
);
    logic [PRESS_COUNT_W-1:0] press_count;
    logic [7:0]               press_sum;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clk          (clock_50Mhz),
            .rst          (reset),
            .raw          (input_RawKey[k]),
            .level        (output_MusicKey[k]),
            .press_pulse  (keyPressPulse[k]),
            .release_pulse(keyReleasePulse[k])
        );
    end

    always_comb begin
        press_sum = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            press_sum = press_sum + 8'(keyPressPulse[i]);
        end
    end

    // Written every cycle so the tally always reflects the register's own value.
    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            press_count <= '0;
        end else begin
            press_count <= sat_add_count(press_count, press_sum);
        end
    end

    always_comb begin
        debugString                   = '0;
        debugString[15:0]             = press_count;
        debugString[16 +: NUM_KEYS]   = output_MusicKey;
    end
endmodule
